conv3x3_engine: RTL and testbench
=================================

CONV3X3_ENGINE -- requirements
Module: conv3x3_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 638, meaning output columns per row (window positions per line).
REQ-002 SHALL have parameter HEIGHT, default 478, meaning output rows per frame.
REQ-003 SHALL have parameter SHIFT, default 8, meaning arithmetic right shift applied to the accumulated sum.
REQ-004 SHALL have ports: clk  in  1  sole clock; rst  in  1  synchronous active-low reset.
REQ-005 SHALL have ports: win_0_0..win_2_2  in  32 each  3x3 window, signed; win_valid  in  1; win_ready  out  1; win_last  in  1  last window of row; win_eof  in  1  frame consumed upstream.
REQ-006 SHALL have ports: w_valid  in  1; w_addr  in  4  tap index 0..8, row-major; w_data  in  8  signed weight.
REQ-007 SHALL have ports: start  in  1  single-cycle pulse; busy  out  1; err  out  1  sticky row-length mismatch.
REQ-008 SHALL have ports: dout  out  32  signed result; dout_valid  out  1; dout_ready  in  1; dout_last  out  1; dout_eof  out  1.

Function
REQ-009 SHALL implement FSM LOAD -> RUN -> FLUSH -> LOAD; reset state LOAD.
REQ-010 In LOAD, each cycle with w_valid and w_addr<=8 SHALL write w_data to weight[w_addr]; w_addr>8 is ignored; w_valid ignored outside LOAD.
REQ-011 LOAD SHALL move to RUN on start; start outside LOAD is ignored.
REQ-012 Window handshake SHALL transfer only when win_valid and win_ready are both 1; win_ready=1 only in RUN and when the pipeline is not stalled.
REQ-013 Pipeline SHALL be 3 stages: S1 nine 32x8 signed products (40 bit); S2 three row sums; S3 total (44 bit), arithmetic shift right SHIFT, saturate to signed 32-bit range.
REQ-014 Latency SHALL be exactly 3 cycles from accepted window to dout_valid with dout_ready held 1; throughput one result per cycle.
REQ-015 Stall: whole pipeline SHALL hold when dout_valid=1 and dout_ready=0; dout and flags stable while stalled; no result dropped or duplicated.
REQ-016 Column counter SHALL increment per accepted window and wrap to 0 on accepted win_last; row counter SHALL increment on accepted win_last.
REQ-017 dout_last SHALL accompany the result of the window that carried win_last.
REQ-018 If win_last is accepted with column counter != WIDTH-1, or column counter reaches WIDTH-1 without win_last, err SHALL set and stay set until reset; the stream continues unaltered.
REQ-019 dout_eof SHALL accompany the result of the last window of row HEIGHT-1; after that window is accepted the FSM SHALL enter FLUSH and deassert win_ready.
REQ-020 Accepted win_eof in RUN SHALL also force FLUSH, with dout_eof on the last in-flight result (or no flag if the pipeline is empty).
REQ-021 FLUSH SHALL return to LOAD once the pipeline is empty and the final result has been accepted; counters clear on entry to LOAD.
REQ-022 busy SHALL be 1 in RUN and FLUSH.
REQ-023 Weights SHALL persist across frames until rewritten.

Reset
REQ-024 On rst=0 at a clk edge: state LOAD, weights 0, counters 0, pipeline valids 0, err 0; outputs win_ready=0, dout=0, dout_valid=0, dout_last=0, dout_eof=0, busy=0.
REQ-025 Reset mid-frame SHALL discard all in-flight results without emitting them.

Configuration
REQ-026 Macro CONV3X3_RELU_EN: when defined, S3 SHALL clamp negative saturated results to 0 (no extra latency); when undefined, signed results pass through.

Structure
REQ-027 Shared package SHALL hold the FSM state typedef, tap count (9), product/accumulator width constants, and saturation limits.
REQ-028 One sub-module conv3x3_row_mac (three products plus sum, one row) SHALL be instantiated three times in S1/S2.

Verification
REQ-029 Identity kernel (weight[4]=256, others 0, SHIFT=8), centre=1234 -> dout=1234 three cycles after accept.
REQ-030 All weights 127, all inputs 0x7FFFFFFF -> dout=0x7FFFFFFF (saturated); inputs 0x80000000 -> 0x80000000, or 0 with CONV3X3_RELU_EN.
REQ-031 dout_ready low for 5 cycles mid-row, WIDTH=4 HEIGHT=2 -> 8 results in order, dout stable while stalled, dout_last on results 4 and 8, dout_eof on 8.
REQ-032 win_last on third window with WIDTH=4 -> err=1, sticky until reset.
REQ-033 rst pulsed low with 2 results in flight -> no dout_valid afterwards, state LOAD, win_ready=0.
REQ-034 start pulsed during RUN and w_valid in RUN -> ignored; weights unchanged, row output unaffected.

Source files
------------

// File: rtl/conv3x3_engine_pkg.sv
// Shared types and constants for the 3x3 convolution engine.
// The optional macro CONV3X3_RELU_EN is consumed by conv3x3_engine.
package conv3x3_engine_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int unsigned TAPS   = 9;
  localparam int unsigned PIX_W  = 32;
  localparam int unsigned WGT_W  = 8;
  localparam int unsigned PROD_W = PIX_W + WGT_W;
  localparam int unsigned ROW_W  = PROD_W + 2;
  localparam int unsigned ACC_W  = PROD_W + 4;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-PIX_W+1){1'b0}}, {(PIX_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-PIX_W+1){1'b1}}, {(PIX_W-1){1'b0}}};

  // Clamp a wide accumulator into the signed 32-bit result range.
  function automatic logic [PIX_W-1:0] sat_pix(input logic signed [ACC_W-1:0] x);
    if (x > SAT_MAX) begin
      return {1'b0, {(PIX_W-1){1'b1}}};
    end else if (x < SAT_MIN) begin
      return {1'b1, {(PIX_W-1){1'b0}}};
    end
    return x[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/conv3x3_row_mac.sv
// One kernel row: three signed products registered (S1), then their sum registered (S2).
module conv3x3_row_mac
  import conv3x3_engine_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_en,
  input  logic signed [PIX_W-1:0] i_pix0,
  input  logic signed [PIX_W-1:0] i_pix1,
  input  logic signed [PIX_W-1:0] i_pix2,
  input  logic signed [WGT_W-1:0] i_wgt0,
  input  logic signed [WGT_W-1:0] i_wgt1,
  input  logic signed [WGT_W-1:0] i_wgt2,
  output logic signed [ROW_W-1:0] o_sum
);

  logic signed [PROD_W-1:0] w_prod0, w_prod1, w_prod2;
  logic signed [PROD_W-1:0] r_prod0, r_prod1, r_prod2;
  logic signed [ROW_W-1:0]  r_sum;

  assign w_prod0 = PROD_W'(i_pix0) * PROD_W'(i_wgt0);
  assign w_prod1 = PROD_W'(i_pix1) * PROD_W'(i_wgt1);
  assign w_prod2 = PROD_W'(i_pix2) * PROD_W'(i_wgt2);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prod0 <= '0;
      r_prod1 <= '0;
      r_prod2 <= '0;
      r_sum   <= '0;
    end else if (i_en) begin
      r_prod0 <= w_prod0;
      r_prod1 <= w_prod1;
      r_prod2 <= w_prod2;
      r_sum   <= ROW_W'(r_prod0) + ROW_W'(r_prod1) + ROW_W'(r_prod2);
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/conv3x3_engine.sv
// Streaming 3x3 convolution with weight load, row/frame tracking and a stallable 3-stage pipeline.
// Define CONV3X3_RELU_EN to clamp negative results to zero in the output stage.
module conv3x3_engine
  import conv3x3_engine_pkg::*;
#(
  parameter int unsigned WIDTH  = 638,
  parameter int unsigned HEIGHT = 478,
  parameter int unsigned SHIFT  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [PIX_W-1:0] win_0_0,
  input  logic signed [PIX_W-1:0] win_0_1,
  input  logic signed [PIX_W-1:0] win_0_2,
  input  logic signed [PIX_W-1:0] win_1_0,
  input  logic signed [PIX_W-1:0] win_1_1,
  input  logic signed [PIX_W-1:0] win_1_2,
  input  logic signed [PIX_W-1:0] win_2_0,
  input  logic signed [PIX_W-1:0] win_2_1,
  input  logic signed [PIX_W-1:0] win_2_2,
  input  logic                    win_valid,
  output logic                    win_ready,
  input  logic                    win_last,
  input  logic                    win_eof,
  input  logic                    w_valid,
  input  logic [3:0]              w_addr,
  input  logic signed [WGT_W-1:0] w_data,
  input  logic                    start,
  output logic                    busy,
  output logic                    err,
  output logic signed [PIX_W-1:0] dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_last,
  output logic                    dout_eof
);

  localparam int unsigned COL_W = $clog2(WIDTH) + 1;
  localparam int unsigned RCW   = $clog2(HEIGHT) + 1;
  localparam logic [COL_W-1:0] COL_END = COL_W'(WIDTH - 1);
  localparam logic [RCW-1:0]   ROW_END = RCW'(HEIGHT - 1);

  state_t r_state, w_state_nxt;
  logic signed [WGT_W-1:0] r_wgt [TAPS];
  logic [COL_W-1:0] r_col;
  logic [RCW-1:0]   r_row;
  logic r_v1, r_v2, r_last1, r_last2, r_eof1, r_eof2;
  logic r_busy, r_err;
  logic signed [PIX_W-1:0] r_dout;
  logic r_dout_valid, r_dout_last, r_dout_eof;

  logic w_stall, w_en, w_accept, w_eof_tag, w_drained;
  logic signed [ROW_W-1:0] w_row0, w_row1, w_row2;
  logic signed [ACC_W-1:0] w_total, w_shifted;
  logic [PIX_W-1:0] w_sat, w_res;

  assign w_stall   = r_dout_valid & ~dout_ready;
  assign w_en      = ~w_stall;
  assign win_ready = (r_state == ST_RUN) & ~w_stall;
  assign w_accept  = win_valid & win_ready;
  // A window closes the frame if it ends the final row or upstream flags end-of-frame with it.
  assign w_eof_tag = (win_last & (r_row == ROW_END)) | win_eof;
  assign w_drained = ~r_v1 & ~r_v2 & (~r_dout_valid | dout_ready);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_LOAD:  if (start) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_accept && w_eof_tag) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (w_drained) w_state_nxt = ST_LOAD;
      default:  w_state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_LOAD;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_LOAD);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < TAPS; i++) r_wgt[i] <= '0;
    end else if (r_state == ST_LOAD && w_valid && w_addr <= 4'(TAPS - 1)) begin
      r_wgt[w_addr] <= w_data;
    end
  end

  // Position tracking; err flags a row whose length disagrees with WIDTH in either direction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_col <= '0;
      r_row <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == ST_FLUSH && w_state_nxt == ST_LOAD) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_accept) begin
        if (win_last) begin
          r_col <= '0;
          r_row <= r_row + RCW'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
      if (w_accept && (win_last != (r_col == COL_END))) r_err <= 1'b1;
    end
  end

  conv3x3_row_mac u_row0 (
    .clk(clk), .rst(rst), .i_en(w_en),
    .i_pix0(win_0_0), .i_pix1(win_0_1), .i_pix2(win_0_2),
    .i_wgt0(r_wgt[0]), .i_wgt1(r_wgt[1]), .i_wgt2(r_wgt[2]),
    .o_sum(w_row0)
  );

  conv3x3_row_mac u_row1 (
    .clk(clk), .rst(rst), .i_en(w_en),
    .i_pix0(win_1_0), .i_pix1(win_1_1), .i_pix2(win_1_2),
    .i_wgt0(r_wgt[3]), .i_wgt1(r_wgt[4]), .i_wgt2(r_wgt[5]),
    .o_sum(w_row1)
  );

  conv3x3_row_mac u_row2 (
    .clk(clk), .rst(rst), .i_en(w_en),
    .i_pix0(win_2_0), .i_pix1(win_2_1), .i_pix2(win_2_2),
    .i_wgt0(r_wgt[6]), .i_wgt1(r_wgt[7]), .i_wgt2(r_wgt[8]),
    .o_sum(w_row2)
  );

  assign w_total   = ACC_W'(w_row0) + ACC_W'(w_row1) + ACC_W'(w_row2);
  assign w_shifted = w_total >>> SHIFT;
  assign w_sat     = sat_pix(w_shifted);
`ifdef CONV3X3_RELU_EN
  assign w_res = w_sat[PIX_W-1] ? '0 : w_sat;
`else
  assign w_res = w_sat;
`endif

  // Valids and sidebands advance in lockstep with the row MAC data registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_v1         <= 1'b0;
      r_v2         <= 1'b0;
      r_last1      <= 1'b0;
      r_last2      <= 1'b0;
      r_eof1       <= 1'b0;
      r_eof2       <= 1'b0;
      r_dout_valid <= 1'b0;
      r_dout_last  <= 1'b0;
      r_dout_eof   <= 1'b0;
      r_dout       <= '0;
    end else if (w_en) begin
      r_v1         <= w_accept;
      r_last1      <= w_accept & win_last;
      r_eof1       <= w_accept & w_eof_tag;
      r_v2         <= r_v1;
      r_last2      <= r_last1;
      r_eof2       <= r_eof1;
      r_dout_valid <= r_v2;
      r_dout_last  <= r_last2;
      r_dout_eof   <= r_eof2;
      if (r_v2) r_dout <= w_res;
    end
  end

  assign busy       = r_busy;
  assign err        = r_err;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign dout_last  = r_dout_last;
  assign dout_eof   = r_dout_eof;

endmodule

// File: tb/tb_conv3x3_engine.sv
// Self-checking bench for conv3x3_engine: constant vector table plus randomized frames
// scored against an arithmetic reference model.
module tb_conv3x3_engine;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned HEIGHT = 2;
  localparam int unsigned SHIFT  = 8;
  localparam longint P_MAX = 64'sd2147483647;
  localparam longint P_MIN = -64'sd2147483648;

  typedef struct packed {
    logic [8:0][7:0]  w;
    logic [8:0][31:0] p;
    logic [31:0]      exp_signed;
    logic [31:0]      exp_relu;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        last;
    logic        eof;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] win [9];
  logic        win_valid, win_ready, win_last, win_eof;
  logic        w_valid;
  logic [3:0]  w_addr;
  logic [7:0]  w_data;
  logic        start, busy, err;
  logic [31:0] dout;
  logic        dout_valid, dout_ready, dout_last, dout_eof;

  int   errors = 0;
  int   checks = 0;
  int   n_results = 0;
  int   m_w [9];
  int   m_rows = 0;
  res_t exp_q [$];
  bit   mon_en = 1'b0;
  bit   stalled = 1'b0;
  res_t held;
  res_t got_e;
  vec_t vecs [8];

  always #5 clk = ~clk;

  conv3x3_engine #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst),
    .win_0_0(win[0]), .win_0_1(win[1]), .win_0_2(win[2]),
    .win_1_0(win[3]), .win_1_1(win[4]), .win_1_2(win[5]),
    .win_2_0(win[6]), .win_2_1(win[7]), .win_2_2(win[8]),
    .win_valid(win_valid), .win_ready(win_ready), .win_last(win_last), .win_eof(win_eof),
    .w_valid(w_valid), .w_addr(w_addr), .w_data(w_data),
    .start(start), .busy(busy), .err(err),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .dout_eof(dout_eof)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit dot product, floor shift, clamp to int32.
  function automatic logic [31:0] ref_conv(input logic [31:0] p [9], input int w [9]);
    longint acc = 0;
    for (int i = 0; i < 9; i++) acc += longint'($signed(p[i])) * longint'(w[i]);
    acc = acc >>> SHIFT;
    if (acc > P_MAX) acc = P_MAX;
    if (acc < P_MIN) acc = P_MIN;
`ifdef CONV3X3_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return acc[31:0];
  endfunction

  function automatic vec_t uniform(input int w, input logic [31:0] p,
                                   input logic [31:0] es, input logic [31:0] er);
    vec_t v;
    for (int i = 0; i < 9; i++) begin
      v.w[i] = 8'(w);
      v.p[i] = p;
    end
    v.exp_signed = es;
    v.exp_relu   = er;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_weights(input int w [9]);
    for (int i = 0; i < 9; i++) begin
      w_valid = 1'b1; w_addr = 4'(i); w_data = 8'(w[i]);
      tick();
      m_w[i] = w[i];
    end
    // Out-of-range tap address must not alias onto a real tap.
    w_addr = 4'd9; w_data = 8'h4D;
    tick();
    w_valid = 1'b0;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_rows = 0;
  endtask

  task automatic send(input logic [31:0] p [9], input logic last, input logic eof);
    res_t e;
    int   n = 0;
    for (int i = 0; i < 9; i++) win[i] = p[i];
    win_last = last; win_eof = eof; win_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (win_ready) break;
      n++;
      if (n > 100) begin
        checks++; errors++;
        $display("FAIL send_timeout: got no win_ready expected win_ready within 100 cycles");
        win_valid = 1'b0;
        return;
      end
    end
    e.d = ref_conv(p, m_w);
    e.last = last;
    e.eof = (last && m_rows == int'(HEIGHT) - 1) || eof;
    if (last) m_rows++;
    exp_q.push_back(e);
    tick();
    win_valid = 1'b0; win_last = 1'b0; win_eof = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  // Scoreboard on the falling edge: compare accepted results, and hold-stability while stalled.
  always @(negedge clk) begin
    if (mon_en) begin
      if (stalled) begin
        check("stall_valid", 32'(dout_valid), 32'd1);
        check("stall_dout", dout, held.d);
        check("stall_flags", {30'd0, dout_last, dout_eof}, {30'd0, held.last, held.eof});
      end
      stalled = 1'b0;
      if (dout_valid) begin
        if (dout_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_result: got 0x%08h expected no result", dout);
          end else begin
            got_e = exp_q.pop_front();
            check("dout", dout, got_e.d);
            check("dout_last", 32'(dout_last), 32'(got_e.last));
            check("dout_eof", 32'(dout_eof), 32'(got_e.eof));
            n_results++;
          end
        end else begin
          stalled = 1'b1;
          held.d = dout; held.last = dout_last; held.eof = dout_eof;
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish before 3ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p [9];
    int          w [9];
    int          base;
    bit          tx_done;
    logic [31:0] want;

    rst = 1'b0; win_valid = 1'b0; win_last = 1'b0; win_eof = 1'b0;
    w_valid = 1'b0; w_addr = '0; w_data = '0; start = 1'b0; dout_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin win[i] = '0; m_w[i] = 0; end
    repeat (3) tick();
    check("rst_win_ready", 32'(win_ready), 32'd0);
    check("rst_dout", dout, 32'd0);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_dout_last", 32'(dout_last), 32'd0);
    check("rst_dout_eof", 32'(dout_eof), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    tick();

    // Unity gain on the centre tap: weight 64 (256 does not fit in 8 bits) with centre 4*1234.
    vecs[0] = uniform(0, 32'h1234_5678, 32'd1234, 32'd1234);
    vecs[0].w[4] = 8'd64; vecs[0].p[4] = 32'd4936;
    vecs[1] = uniform(127, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    vecs[2] = uniform(127, 32'h8000_0000, 32'h8000_0000, 32'h0);
    vecs[3] = uniform(1, 32'd256, 32'd9, 32'd9);
    vecs[4] = uniform(-1, 32'd256, 32'hFFFF_FFF7, 32'h0);
    vecs[5] = uniform(0, 32'h0, 32'hFFFF_FFFF, 32'h0);
    vecs[5].w[0] = 8'd1; vecs[5].p[0] = 32'hFFFF_FFFF;
    vecs[6] = uniform(0, 32'd512, 32'd90, 32'd90);
    for (int i = 0; i < 9; i++) vecs[6].w[i] = 8'(i + 1);
    vecs[7] = uniform(0, 32'h0, 32'hFF80_0000, 32'h0);
    vecs[7].w[8] = 8'h80; vecs[7].p[8] = 32'h00FF_FFFF;

    // Single-window frames closed by win_eof; latency and value checked directly.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 9; i++) begin
        w[i] = int'($signed(vecs[k].w[i]));
        p[i] = vecs[k].p[i];
      end
`ifdef CONV3X3_RELU_EN
      want = vecs[k].exp_relu;
`else
      want = vecs[k].exp_signed;
`endif
      load_weights(w);
      start_frame();
      check("tbl_busy_run", 32'(busy), 32'd1);
      send(p, 1'b0, 1'b1);
      check("tbl_lat_c1", 32'(dout_valid), 32'd0);
      tick();
      check("tbl_lat_c2", 32'(dout_valid), 32'd0);
      tick();
      check("tbl_lat_c3_valid", 32'(dout_valid), 32'd1);
      check($sformatf("tbl_dout_%0d", k), dout, want);
      check("tbl_eof", {30'd0, dout_last, dout_eof}, 32'd1);
      wait_idle("tbl_idle");
    end
    check("tbl_err", 32'(err), 32'd0);
    exp_q.delete();

    // Full 4x2 frame with a 5-cycle output stall; start/w_valid during RUN must be ignored.
    for (int i = 0; i < 9; i++) w[i] = int'($urandom_range(255)) - 128;
    load_weights(w);
    mon_en = 1'b1;
    base = n_results;
    start_frame();
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          for (int i = 0; i < 9; i++) p[i] = $urandom;
          send(p, 1'(k % 4 == 3), 1'b0);
          if (k == 1) begin
            start = 1'b1; w_valid = 1'b1; w_addr = 4'd0; w_data = 8'h63;
          end
          if (k == 2) begin
            start = 1'b0; w_valid = 1'b0;
          end
        end
      end
      begin
        repeat (4) tick();
        dout_ready = 1'b0;
        repeat (5) tick();
        dout_ready = 1'b1;
      end
    join
    wait_idle("stall_idle");
    check("stall_count", 32'(n_results - base), 32'd8);
    check("stall_q_empty", 32'(exp_q.size()), 32'd0);
    check("stall_err", 32'(err), 32'd0);

    // Second frame with the same weights and random backpressure.
    base = n_results;
    tx_done = 1'b0;
    start_frame();
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          for (int i = 0; i < 9; i++) p[i] = $urandom;
          send(p, 1'(k % 4 == 3), 1'b0);
        end
        tx_done = 1'b1;
      end
      begin
        while (!tx_done) begin
          tick();
          dout_ready = ($urandom_range(2) != 0);
        end
        dout_ready = 1'b1;
      end
    join
    wait_idle("rand_idle");
    check("rand_count", 32'(n_results - base), 32'd8);
    check("rand_q_empty", 32'(exp_q.size()), 32'd0);

    // Short row: win_last on the third window sets a sticky err.
    start_frame();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 9; i++) p[i] = $urandom;
      send(p, 1'(k == 2), 1'b0);
      if (k == 1) check("short_err_before", 32'(err), 32'd0);
    end
    check("short_err_set", 32'(err), 32'd1);
    send(p, 1'b0, 1'b1);
    wait_idle("short_idle");
    check("short_err_sticky", 32'(err), 32'd1);
    check("short_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset with two results in flight: nothing emerges, engine back in LOAD.
    start_frame();
    mon_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 9; i++) p[i] = $urandom;
      send(p, 1'b0, 1'b0);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_q.delete();
    stalled = 1'b0;
    base = 0;
    for (int c = 0; c < 6; c++) begin
      if (dout_valid) base++;
      tick();
    end
    check("rstmid_no_valid", 32'(base), 32'd0);
    check("rstmid_win_ready", 32'(win_ready), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_err", 32'(err), 32'd0);
    check("rstmid_dout", dout, 32'd0);

    // Long row: a fourth window without win_last also flags err.
    for (int i = 0; i < 9; i++) w[i] = int'($urandom_range(255)) - 128;
    load_weights(w);
    mon_en = 1'b1;
    start_frame();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 9; i++) p[i] = $urandom;
      send(p, 1'b0, 1'b0);
      if (k == 2) check("long_err_before", 32'(err), 32'd0);
    end
    check("long_err_set", 32'(err), 32'd1);
    send(p, 1'b0, 1'b1);
    wait_idle("long_idle");
    check("long_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
